// File: rtl/data_memory.sv
// data_memory: multi-channel word memory with fixed-latency request/response FSM per channel
module data_memory #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
   input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]           mem_read_ready,
   output logic [DATA_BITS*NUM_CHANNELS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
   input  logic [ADDR_BITS*NUM_CHANNELS-1:0] mem_write_address,
   input  logic [DATA_BITS*NUM_CHANNELS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]           mem_write_ready,
   input  logic                              init_write_enable,
   input  logic [ADDR_BITS-1:0]              init_address,
   input  logic [DATA_BITS-1:0]              init_data,
   output logic                              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

   state_e [NUM_CHANNELS-1:0]                 state_q;
   logic   [NUM_CHANNELS-1:0]                 kind_q;
   logic   [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  addr_q;
   logic   [NUM_CHANNELS-1:0][DATA_BITS-1:0]  wdata_q;
   logic   [NUM_CHANNELS-1:0][3:0]            cnt_q;
   logic   [NUM_CHANNELS-1:0]                 commit_d;
   logic   [DATA_BITS-1:0]                    mem_q [2**ADDR_BITS];

   // a channel commits its write on the WAIT->RESPOND edge; busy reflects any non-idle channel
   always_comb begin
      busy     = 1'b0;
      commit_d = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         busy        = busy | (state_q[c] != IDLE);
         commit_d[c] = (state_q[c] == WAIT) && (cnt_q[c] == '0) && kind_q[c];
      end
   end

   // per-channel request FSM with registered ready/data outputs; read wins over write in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= IDLE;
            kind_q[c]  <= 1'b0;
            addr_q[c]  <= '0;
            wdata_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         mem_read_data   <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
               IDLE: begin
                  if (mem_read_valid[c]) begin
                     addr_q[c]  <= mem_read_address[c*ADDR_BITS +: ADDR_BITS];
                     kind_q[c]  <= 1'b0;
                     cnt_q[c]   <= 4'(LATENCY - 1);
                     state_q[c] <= WAIT;
                  end else if (mem_write_valid[c]) begin
                     addr_q[c]  <= mem_write_address[c*ADDR_BITS +: ADDR_BITS];
                     wdata_q[c] <= mem_write_data[c*DATA_BITS +: DATA_BITS];
                     kind_q[c]  <= 1'b1;
                     cnt_q[c]   <= 4'(LATENCY - 1);
                     state_q[c] <= WAIT;
                  end
               end
               WAIT: begin
                  if (cnt_q[c] == '0) begin
                     state_q[c] <= RESPOND;
                     if (kind_q[c]) begin
                        mem_write_ready[c] <= 1'b1;
                     end else begin
                        mem_read_ready[c] <= 1'b1;
                        mem_read_data[c*DATA_BITS +: DATA_BITS] <= mem_q[addr_q[c]];
                     end
                  end else begin
                     cnt_q[c] <= cnt_q[c] - 4'd1;
                  end
               end
               RESPOND: begin
                  if (!(kind_q[c] ? mem_write_valid[c] : mem_read_valid[c])) begin
                     state_q[c]         <= IDLE;
                     mem_read_ready[c]  <= 1'b0;
                     mem_write_ready[c] <= 1'b0;
                  end
               end
               default: state_q[c] <= IDLE;
            endcase
         end
      end
   end

   // storage is never reset; host preload first so any channel write to the same word overrides it,
   // and later channels override earlier ones
   always_ff @(posedge clk) begin
      if (init_write_enable) mem_q[init_address] <= init_data;
      for (int c = 0; c < NUM_CHANNELS; c++)
         if (commit_d[c]) mem_q[addr_q[c]] <= wdata_q[c];
   end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed table-driven and sequence checks for data_memory (LATENCY=2)
module tb_data_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rv = '0, wv = '0, rr, wr;
   logic [31:0] raddr = '0, waddr = '0, wdata = '0, rdata;
   logic        init_we = 1'b0;
   logic [7:0]  init_a = '0, init_d = '0;
   logic        busy;
   int          n_cmp = 0, n_err = 0;

   typedef struct {
      int         ch;
      bit         wr;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [8];

   data_memory #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .mem_read_valid(rv), .mem_read_address(raddr), .mem_read_ready(rr), .mem_read_data(rdata),
      .mem_write_valid(wv), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wr),
      .init_write_enable(init_we), .init_address(init_a), .init_data(init_d), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      init_we = 1'b1;
      init_a  = a;
      init_d  = d;
      tick();
      init_we = 1'b0;
   endtask

   function automatic logic rdy(input int ch, input bit w);
      return w ? wr[ch] : rr[ch];
   endfunction

   // one full transaction: accept, two waiting edges, respond, hold one edge, drop and return to idle
   task automatic txn(input int ch, input bit w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
      if (w) begin
         wv[ch] = 1'b1;
         waddr[ch*8 +: 8] = a;
         wdata[ch*8 +: 8] = d;
      end else begin
         rv[ch] = 1'b1;
         raddr[ch*8 +: 8] = a;
      end
      tick();
      check("accept_busy", busy, 1'b1);
      check("rdy_e1", rdy(ch, w), 1'b0);
      waddr[ch*8 +: 8] = ~a;
      wdata[ch*8 +: 8] = ~d;
      raddr[ch*8 +: 8] = ~a;
      tick();
      check("rdy_e2", rdy(ch, w), 1'b0);
      tick();
      check("rdy_e3", rdy(ch, w), 1'b1);
      check("other_rdy_e3", rdy(ch, !w), 1'b0);
      if (!w) check("rdata_e3", rdata[ch*8 +: 8], exp);
      tick();
      check("rdy_hold", rdy(ch, w), 1'b1);
      if (!w) check("rdata_hold", rdata[ch*8 +: 8], exp);
      rv[ch] = 1'b0;
      wv[ch] = 1'b0;
      tick();
      check("rdy_drop", rdy(ch, w), 1'b0);
      check("busy_idle", busy, 1'b0);
   endtask

   initial begin
      vecs[0] = '{ch: 0, wr: 1'b0, a: 8'h10, d: 8'h00, exp: 8'hAB};
      vecs[1] = '{ch: 1, wr: 1'b1, a: 8'h20, d: 8'h55, exp: 8'h00};
      vecs[2] = '{ch: 2, wr: 1'b0, a: 8'h20, d: 8'h00, exp: 8'h55};
      vecs[3] = '{ch: 3, wr: 1'b0, a: 8'hFF, d: 8'h00, exp: 8'h5A};
      vecs[4] = '{ch: 0, wr: 1'b1, a: 8'h00, d: 8'hC3, exp: 8'h00};
      vecs[5] = '{ch: 1, wr: 1'b0, a: 8'h00, d: 8'h00, exp: 8'hC3};
      vecs[6] = '{ch: 2, wr: 1'b1, a: 8'hFF, d: 8'hA5, exp: 8'h00};
      vecs[7] = '{ch: 3, wr: 1'b0, a: 8'hFF, d: 8'h00, exp: 8'hA5};

      #3 reset = 1'b0;
      #1;
      check("reset_rr", rr, 4'h0);
      check("reset_wr", wr, 4'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_busy", busy, 1'b0);
      tick();
      tick();
      reset = 1'b1;

      preload(8'h10, 8'hAB);
      preload(8'h11, 8'hCD);
      preload(8'h12, 8'hEF);
      preload(8'h13, 8'h01);
      preload(8'hFF, 8'h5A);
      preload(8'h40, 8'h05);
      preload(8'h50, 8'h44);

      for (int i = 0; i < 8; i++)
         txn(vecs[i].ch, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp);

      // same-edge writes from channels 0 and 3 plus a host preload to 0x30
      wv = 4'b1001;
      waddr = 32'h30_00_00_30;
      wdata = 32'h33_00_00_11;
      tick();
      tick();
      init_we = 1'b1;
      init_a  = 8'h30;
      init_d  = 8'hEE;
      tick();
      init_we = 1'b0;
      check("multi_wr_ready", wr, 4'b1001);
      wv = 4'b0000;
      tick();
      txn(1, 1'b0, 8'h30, 8'h00, 8'h33);

      // read and write both valid on channel 0: read first, write after read drops
      rv[0] = 1'b1;
      raddr[7:0] = 8'h10;
      wv[0] = 1'b1;
      waddr[7:0] = 8'h31;
      wdata[7:0] = 8'h77;
      tick();
      tick();
      tick();
      check("rw_read_ready", rr[0], 1'b1);
      check("rw_write_not_yet", wr[0], 1'b0);
      check("rw_read_data", rdata[7:0], 8'hAB);
      rv[0] = 1'b0;
      tick();
      check("rw_read_drop", rr[0], 1'b0);
      check("rw_wr_e4", wr[0], 1'b0);
      tick();
      check("rw_wr_e5", wr[0], 1'b0);
      tick();
      check("rw_wr_e6", wr[0], 1'b0);
      tick();
      check("rw_wr_e7", wr[0], 1'b1);
      wv[0] = 1'b0;
      tick();
      txn(0, 1'b0, 8'h31, 8'h00, 8'h77);

      // read-before-write: channel 1 reads 0x50 on the edge channel 0 writes it
      wv[0] = 1'b1;
      waddr[7:0] = 8'h50;
      wdata[7:0] = 8'h99;
      rv[1] = 1'b1;
      raddr[15:8] = 8'h50;
      tick();
      tick();
      tick();
      check("rbw_rr", rr, 4'b0010);
      check("rbw_wr", wr, 4'b0001);
      check("rbw_old_data", rdata[15:8], 8'h44);
      wv = '0;
      rv = '0;
      tick();
      txn(2, 1'b0, 8'h50, 8'h00, 8'h99);

      // all channels read distinct preloaded words together
      rv = 4'hF;
      raddr = 32'h13_12_11_10;
      tick();
      check("all_busy_e1", busy, 1'b1);
      tick();
      check("all_busy_e2", busy, 1'b1);
      check("all_rr_e2", rr, 4'h0);
      tick();
      check("all_busy_e3", busy, 1'b1);
      check("all_rr_e3", rr, 4'hF);
      check("all_rdata", rdata, 32'h01_EF_CD_AB);
      rv = '0;
      tick();
      check("all_rr_drop", rr, 4'h0);
      check("all_busy_drop", busy, 1'b0);

      // reset aborts a pending write on ch1 while ch0 sits in RESPOND
      rv[0] = 1'b1;
      raddr[7:0] = 8'h10;
      tick();
      tick();
      tick();
      check("abort_pre_rr", rr[0], 1'b1);
      wv[1] = 1'b1;
      waddr[15:8] = 8'h40;
      wdata[15:8] = 8'h77;
      tick();
      check("abort_pre_busy", busy, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("abort_rr", rr, 4'h0);
      check("abort_wr", wr, 4'h0);
      check("abort_rdata", rdata, 32'h0);
      check("abort_busy", busy, 1'b0);
      rv = '0;
      wv = '0;
      tick();
      tick();
      reset = 1'b1;
      txn(2, 1'b0, 8'h40, 8'h00, 8'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
